// File: rtl/hba_slave_regs.sv
// HBA bus slave with four byte registers (reg0, reg1, int_mask, status) and a
// masked rising-edge interrupt on slave_status_in. Single-cycle acknowledge.
//
//   state | meaning
//   IDLE  | waiting for a select with matching peripheral nibble
//   ACK   | acknowledge cycle; read data on bus, write already applied
//   HOLD  | waiting for the master to drop select before the next transfer
module hba_slave_regs #(
    parameter int DBUS_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int PERIPH_ADDR = 0
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset,
    input  logic                  hba_rnw,
    input  logic                  hba_select,
    input  logic [ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic                  hba_xferack_slave,
    output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
    output logic                  hba_interrupt_slave,
    input  logic [DBUS_WIDTH-1:0] slave_status_in,
    output logic [DBUS_WIDTH-1:0] slave_reg0_out,
    output logic [DBUS_WIDTH-1:0] slave_reg1_out
);

    localparam logic [3:0] PERIPH_SEL = 4'(PERIPH_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state;
    logic [DBUS_WIDTH-1:0] int_mask;
    logic [DBUS_WIDTH-1:0] pending;
    logic [DBUS_WIDTH-1:0] prev_status;
    logic                  status_rd;

    logic                  hit;
    logic [7:0]            reg_idx;
    logic [DBUS_WIDTH-1:0] rd_data;
    logic [DBUS_WIDTH-1:0] edge_vec;
    logic [DBUS_WIDTH-1:0] pending_nxt;

    always_comb begin
        hit      = hba_select && (hba_abus[ADDR_WIDTH-1 -: 4] == PERIPH_SEL);
        reg_idx  = hba_abus[7:0];
        edge_vec = slave_status_in & ~prev_status & int_mask;
        rd_data  = '0;
        case (reg_idx)
            8'h00:   rd_data = slave_reg0_out;
            8'h01:   rd_data = slave_reg1_out;
            8'h02:   rd_data = int_mask;
            8'h03:   rd_data = slave_status_in;
            default: rd_data = '0;
        endcase
        // a fresh edge in the clearing cycle survives the clear
        pending_nxt = ((state == ST_ACK && status_rd) ? '0 : pending) | edge_vec;
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state               <= ST_IDLE;
            slave_reg0_out      <= '0;
            slave_reg1_out      <= '0;
            int_mask            <= '0;
            pending             <= '0;
            prev_status         <= slave_status_in;
            status_rd           <= 1'b0;
            hba_xferack_slave   <= 1'b0;
            hba_dbus_slave      <= '0;
            hba_interrupt_slave <= 1'b0;
        end else begin
            prev_status         <= slave_status_in;
            pending             <= pending_nxt;
            hba_interrupt_slave <= |pending;
            hba_xferack_slave   <= 1'b0;
            hba_dbus_slave      <= '0;

            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state             <= ST_ACK;
                        hba_xferack_slave <= 1'b1;
                        status_rd         <= hba_rnw && (reg_idx == 8'h03);
                        if (hba_rnw) begin
                            hba_dbus_slave <= rd_data;
                        end else begin
                            case (reg_idx)
                                8'h00:   slave_reg0_out <= hba_dbus;
                                8'h01:   slave_reg1_out <= hba_dbus;
                                8'h02:   int_mask       <= hba_dbus;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ACK: begin
                    state     <= ST_HOLD;
                    status_rd <= 1'b0;
                end
                ST_HOLD: begin
                    if (!hba_select) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hba_slave_regs.sv
// Self-checking bench for hba_slave_regs: directed table, interrupt/reset
// sequences, and randomized transfers against a register-array model.
module tb_hba_slave_regs;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam logic [3:0] PSEL = 4'h5;

    logic          hba_clk = 1'b0;
    logic          hba_reset;
    logic          hba_rnw;
    logic          hba_select;
    logic [AW-1:0] hba_abus;
    logic [DW-1:0] hba_dbus;
    logic          hba_xferack_slave;
    logic [DW-1:0] hba_dbus_slave;
    logic          hba_interrupt_slave;
    logic [DW-1:0] slave_status_in;
    logic [DW-1:0] slave_reg0_out;
    logic [DW-1:0] slave_reg1_out;

    int total = 0;
    int bad   = 0;

    hba_slave_regs #(.DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .PERIPH_ADDR(5)) dut (
        .hba_clk             (hba_clk),
        .hba_reset           (hba_reset),
        .hba_rnw             (hba_rnw),
        .hba_select          (hba_select),
        .hba_abus            (hba_abus),
        .hba_dbus            (hba_dbus),
        .hba_xferack_slave   (hba_xferack_slave),
        .hba_dbus_slave      (hba_dbus_slave),
        .hba_interrupt_slave (hba_interrupt_slave),
        .slave_status_in     (slave_status_in),
        .slave_reg0_out      (slave_reg0_out),
        .slave_reg1_out      (slave_reg1_out)
    );

    always #5 hba_clk = ~hba_clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hba_clk);
        #1;
    endtask

    // Holds select for nsel cycles then two idle cycles; counts every ack seen
    // and flags any non-zero read data outside an ack cycle.
    task automatic do_xfer(input bit rnw, input bit hit, input logic [7:0] idx,
                           input logic [7:0] wdata, input int nsel,
                           output int acks, output int first_ack,
                           output logic [7:0] rdat, output bit dbus_bad);
        acks = 0; first_ack = -1; rdat = '0; dbus_bad = 1'b0;
        hba_select = 1'b1;
        hba_rnw    = rnw;
        hba_abus   = {(hit ? PSEL : 4'hA), idx};
        hba_dbus   = wdata;
        for (int i = 0; i < nsel + 2; i++) begin
            tick();
            if (hba_xferack_slave) begin
                acks++;
                if (first_ack < 0) first_ack = i;
                rdat = hba_dbus_slave;
            end else if (hba_dbus_slave != '0) begin
                dbus_bad = 1'b1;
            end
            if (i == nsel - 1) begin
                hba_select = 1'b0;
                hba_abus   = '0;
                hba_dbus   = '0;
            end
        end
    endtask

    typedef struct {
        bit         rnw;
        bit         hit;
        logic [7:0] idx;
        logic [7:0] wdata;
        int         exp_acks;
        logic [7:0] exp_rdat;
        logic [7:0] exp_reg0;
        logic [7:0] exp_reg1;
    } vec_t;

    vec_t tbl[11];

    logic [7:0] mreg[3];

    initial begin
        int acks, first_ack;
        logic [7:0] rdat;
        bit dbus_bad;

        tbl[0]  = '{0, 1, 8'h01, 8'h3C, 1, 8'h00, 8'hA5, 8'h3C};
        tbl[1]  = '{1, 1, 8'h01, 8'h00, 1, 8'h3C, 8'hA5, 8'h3C};
        tbl[2]  = '{0, 0, 8'h00, 8'h77, 0, 8'h00, 8'hA5, 8'h3C};
        tbl[3]  = '{1, 1, 8'h10, 8'h00, 1, 8'h00, 8'hA5, 8'h3C};
        tbl[4]  = '{0, 1, 8'h10, 8'hFF, 1, 8'h00, 8'hA5, 8'h3C};
        tbl[5]  = '{0, 1, 8'h03, 8'h55, 1, 8'h00, 8'hA5, 8'h3C};
        tbl[6]  = '{0, 1, 8'h02, 8'h00, 1, 8'h00, 8'hA5, 8'h3C};
        tbl[7]  = '{1, 1, 8'h02, 8'h00, 1, 8'h00, 8'hA5, 8'h3C};
        tbl[8]  = '{1, 0, 8'h00, 8'h00, 0, 8'h00, 8'hA5, 8'h3C};
        tbl[9]  = '{1, 1, 8'h00, 8'h00, 1, 8'hA5, 8'hA5, 8'h3C};
        tbl[10] = '{1, 1, 8'h03, 8'h00, 1, 8'h5A, 8'hA5, 8'h3C};

        hba_reset = 1'b1; hba_rnw = 1'b0; hba_select = 1'b0;
        hba_abus = '0; hba_dbus = '0; slave_status_in = '0;
        repeat (3) tick();
        hba_reset = 1'b0;
        tick();
        chk("rst_ack", hba_xferack_slave, 0);
        chk("rst_dbus", hba_dbus_slave, 0);
        chk("rst_int", hba_interrupt_slave, 0);
        chk("rst_reg0", slave_reg0_out, 0);
        chk("rst_reg1", slave_reg1_out, 0);

        // write held four cycles: one ack, right after the first select cycle
        do_xfer(0, 1, 8'h00, 8'hA5, 4, acks, first_ack, rdat, dbus_bad);
        chk("w0_acks", acks, 1);
        chk("w0_ack_pos", first_ack, 0);
        chk("w0_reg0", slave_reg0_out, 8'hA5);
        chk("w0_dbus_idle", dbus_bad, 0);
        chk("w0_dbus_ack", rdat, 0);

        slave_status_in = 8'h5A;
        for (int v = 0; v < 11; v++) begin
            do_xfer(tbl[v].rnw, tbl[v].hit, tbl[v].idx, tbl[v].wdata, 2,
                    acks, first_ack, rdat, dbus_bad);
            chk($sformatf("tbl%0d_acks", v), acks, tbl[v].exp_acks);
            chk($sformatf("tbl%0d_rdat", v), rdat, tbl[v].exp_rdat);
            chk($sformatf("tbl%0d_reg0", v), slave_reg0_out, tbl[v].exp_reg0);
            chk($sformatf("tbl%0d_reg1", v), slave_reg1_out, tbl[v].exp_reg1);
            chk($sformatf("tbl%0d_dbus_idle", v), dbus_bad, 0);
        end

        // interrupt: masked rising edge, status read clears it
        slave_status_in = 8'h00;
        repeat (2) tick();
        do_xfer(0, 1, 8'h02, 8'h01, 2, acks, first_ack, rdat, dbus_bad);
        slave_status_in = 8'h01;
        tick();
        chk("int_one_cycle", hba_interrupt_slave, 0);
        tick();
        chk("int_two_cycles", hba_interrupt_slave, 1);
        do_xfer(1, 1, 8'h03, 8'h00, 2, acks, first_ack, rdat, dbus_bad);
        chk("int_rd_status", rdat, 8'h01);
        chk("int_cleared", hba_interrupt_slave, 0);
        slave_status_in = 8'h03;
        repeat (3) tick();
        chk("int_masked_edge", hba_interrupt_slave, 0);
        do_xfer(0, 1, 8'h02, 8'h03, 2, acks, first_ack, rdat, dbus_bad);
        repeat (2) tick();
        chk("int_no_retro", hba_interrupt_slave, 0);

        // edge arriving in the ack cycle of a status read is kept
        slave_status_in = 8'h02;
        repeat (2) tick();
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = {PSEL, 8'h03};
        tick();
        chk("race_ack", hba_xferack_slave, 1);
        chk("race_rdat", hba_dbus_slave, 8'h02);
        slave_status_in = 8'h03;
        tick();
        chk("race_no_second_ack", hba_xferack_slave, 0);
        tick();
        chk("race_int_set", hba_interrupt_slave, 1);
        hba_select = 1'b0;
        repeat (2) tick();
        chk("race_int_held", hba_interrupt_slave, 1);
        do_xfer(1, 1, 8'h03, 8'h00, 2, acks, first_ack, rdat, dbus_bad);
        chk("race_int_cleared", hba_interrupt_slave, 0);

        // reset in HOLD with select held high
        slave_status_in = 8'h00;
        tick();
        slave_status_in = 8'h01;
        repeat (3) tick();
        chk("rst2_int_before", hba_interrupt_slave, 1);
        hba_select = 1'b1; hba_rnw = 1'b0; hba_abus = {PSEL, 8'h00}; hba_dbus = 8'h11;
        tick();
        chk("rst2_first_ack", hba_xferack_slave, 1);
        chk("rst2_reg0_written", slave_reg0_out, 8'h11);
        tick();
        hba_reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst2_ack_in_reset", hba_xferack_slave, 0);
            chk("rst2_dbus_in_reset", hba_dbus_slave, 0);
            chk("rst2_int_in_reset", hba_interrupt_slave, 0);
            chk("rst2_reg0_in_reset", slave_reg0_out, 0);
        end
        hba_reset = 1'b0;
        hba_rnw = 1'b1; hba_abus = {PSEL, 8'h01};
        tick();
        chk("rst2_ack_after", hba_xferack_slave, 1);
        chk("rst2_rdat_after", hba_dbus_slave, 0);
        hba_select = 1'b0;
        repeat (2) tick();

        // randomized transfers against a register-array model
        for (int k = 0; k < 3; k++) mreg[k] = '0;
        for (int n = 0; n < 60; n++) begin
            bit         r_rnw, r_hit;
            logic [7:0] r_idx, r_wd, exp_rd, r_st;
            int         r_nsel;
            r_rnw  = 1'($urandom_range(0, 1));
            r_hit  = ($urandom_range(0, 3) != 0);
            r_idx  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            r_wd   = 8'($urandom);
            r_st   = 8'($urandom);
            r_nsel = $urandom_range(2, 4);
            slave_status_in = r_st;
            tick();
            exp_rd = '0;
            if (r_hit && r_rnw) begin
                if (r_idx < 8'd3)       exp_rd = mreg[r_idx[1:0]];
                else if (r_idx == 8'd3) exp_rd = r_st;
            end
            do_xfer(r_rnw, r_hit, r_idx, r_wd, r_nsel, acks, first_ack, rdat, dbus_bad);
            if (r_hit && !r_rnw && r_idx < 8'd3) mreg[r_idx[1:0]] = r_wd;
            chk($sformatf("rnd%0d_acks", n), acks, r_hit ? 1 : 0);
            chk($sformatf("rnd%0d_rdat", n), rdat, exp_rd);
            chk($sformatf("rnd%0d_reg0", n), slave_reg0_out, mreg[0]);
            chk($sformatf("rnd%0d_reg1", n), slave_reg1_out, mreg[1]);
            chk($sformatf("rnd%0d_dbus_idle", n), dbus_bad, 0);
            if (r_hit) chk($sformatf("rnd%0d_ack_pos", n), first_ack, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
